ex_mem_pipe: RTL and testbench
==============================

# ex_mem_pipe

EX→MEM pipeline register for the 16-bit core. It captures the EX-stage result bundle on each clock and presents it to the MEM stage's data memory port and writeback controls. It holds the architectural N/Z/V flag register and resolves conditional branches and jumps into a single-cycle registered `PCSrc` redirect pulse. Stall and flush inputs from the hazard unit control it.

## Interface
- `BR_W`, 3: branch opcode width. Encodings: BNEQ=000, BEQ=001, BGT=010, BLT=011, BGTE=100, BLTE=101, BOVFL=110, BUNCOND=111.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `stall` in 1: hold all MEM-side state.
- `flush` in 1: discard the incoming EX instruction and load a bubble.
- `ex_valid` in 1: EX holds a real instruction.
- `ex_aluOut` in 16: ALU result, used as the memory address.
- `ex_wrData` in 16: store data.
- `ex_pcTarget` in 16: branch/jump target.
- `ex_dstReg` in 4, `ex_regWr` in 1: writeback destination and write enable.
- `ex_memWr` in 1, `ex_memRd` in 1: memory write and read requests.
- `ex_sawBr` in 1, `ex_sawJ` in 1, `ex_branchOp` in 3: branch and jump decode.
- `ex_setFlags` in 1, `ex_flags` in 3: flag-setting instruction and its {N,Z,V}.
- `memAddr` out 16, `wrData` out 16, `memWr` out 1, `memRd` out 1: to the MEM stage and data memory.
- `dstReg` out 4, `regWr` out 1, `valid` out 1: forwarded toward writeback.
- `flags` out 3: architectural {N,Z,V}.
- `PCSrc` out 1, `pcTarget` out 16: fetch redirect.

## Operation
- Load condition: `load = ~stall`. The next bundle is the EX bundle when `ex_valid & ~flush`; otherwise it is a bubble.
- Bubble: `valid`, `memWr`, `memRd`, `regWr` and all branch state are 0. Data fields keep their old values and are don't-care.
- `memWr`, `memRd` and `regWr` are gated by valid. They are never 1 while `valid` is 0.
- Flag register:
  - Updates to `ex_flags` only when a valid, non-flushed instruction with `ex_setFlags` = 1 loads.
  - Otherwise it holds, including across stalls and bubbles.
- Branch compare, evaluated combinationally at load time:
  - Conditions: BNEQ ~Z; BEQ Z; BGT ~Z&~N; BLT N; BGTE ~N; BLTE N|Z; BOVFL V; BUNCOND 1.
  - Evaluation uses the current `flags` register. That value already includes the flag-setter now sitting in MEM.
  - `taken = ex_valid & ~flush & ((ex_sawBr & cmp) | ex_sawJ)`.
  - If the loaded instruction has both `ex_sawBr` and `ex_setFlags`, the compare uses the pre-update flags.
- Redirect pulse:
  - Internal bit `taken_r` loads `taken`. `PCSrc = taken_r & ~fired`.
  - `fired` sets on the first cycle `PCSrc` is 1 and clears on every load.
  - Net effect: `PCSrc` is high for exactly one cycle per taken branch or jump, even if `stall` holds the instruction in MEM.
- Priority:
  - `stall` overrides `flush`. A flush during stall is ignored, and the hazard unit keeps `flush` asserted until the stall drops.
  - Reset overrides everything.

## Timing
- Latency: EX inputs sampled at edge N appear on the outputs after edge N. They are fully registered, with no combinational path from inputs to outputs.
- `PCSrc` is registered. It rises in the cycle after the branch is captured and falls after one cycle.
- Stall: every output and the flag register hold their values. `PCSrc` stays 0 after its single pulse.
- Reset (`rst_n` = 0, asynchronous):
  - Outputs: `valid`, `memWr`, `memRd`, `regWr`, `PCSrc` = 0; `memAddr`, `wrData`, `pcTarget` = 16'h0000; `dstReg` = 4'h0; `flags` = 3'b000.
  - Internal: `taken_r` = 0, `fired` = 0.
  - A reset asserted mid-stall or during a `PCSrc` pulse drops every output immediately.
- Release: the first capture happens on the first rising edge with `rst_n` = 1.
- Back-to-back taken branches on consecutive loads produce two separate one-cycle `PCSrc` pulses.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with `memWr`=1 → all outputs, including `flags`, go to 0 before the next edge. Release, load a valid LW with `ex_aluOut`=16'h0040 → next cycle `memRd`=1, `memAddr`=16'h0040, `valid`=1.
- **Flags + BEQ:**
  - Cycle 1: load SUB with `ex_setFlags`=1, `ex_flags`=3'b010.
  - Cycle 2: load BEQ with `ex_pcTarget`=16'h0123 → `flags`=010 and the branch is taken.
  - Cycle 3: `PCSrc`=1, `pcTarget`=16'h0123.
  - Cycle 4: `PCSrc`=0.
  - Repeat with BNEQ → `PCSrc` stays 0.
- **Condition sweep:** for each of the 8 branch ops, with `flags` ∈ {000, 001, 010, 100} → `PCSrc` matches the compare table (e.g. BLTE with 100 → 1; BGT with 010 → 0; BOVFL with 001 → 1). JMP with `ex_sawJ`=1 → `PCSrc`=1 for any flags.
- **Stall hold:** a taken branch captured, then `stall`=1 for 3 cycles → `PCSrc` is 1 only in the first cycle and all other outputs stay constant. A flag-setter presented during the stall does not change `flags`.
- **Flush:** valid SW with `ex_setFlags`=1 and `flush`=1 → next cycle `valid`=0, `memWr`=0, `flags` unchanged. With `flush`=1 and `stall`=1 together → previous contents held.
- **Gating:** `ex_valid`=0 with `ex_memWr`=1, `ex_regWr`=1, `ex_sawJ`=1 → `memWr`=0, `regWr`=0, `PCSrc`=0.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline register for the 16-bit core.
// Captures the EX result bundle, holds the architectural N/Z/V flags and
// turns a resolved branch or jump into a one-cycle PCSrc redirect pulse.
module ex_mem_pipe #(
  parameter int BR_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [15:0]     ex_aluOut,
  input  logic [15:0]     ex_wrData,
  input  logic [15:0]     ex_pcTarget,
  input  logic [3:0]      ex_dstReg,
  input  logic            ex_regWr,
  input  logic            ex_memWr,
  input  logic            ex_memRd,
  input  logic            ex_sawBr,
  input  logic            ex_sawJ,
  input  logic [BR_W-1:0] ex_branchOp,
  input  logic            ex_setFlags,
  input  logic [2:0]      ex_flags,
  output logic [15:0]     memAddr,
  output logic [15:0]     wrData,
  output logic            memWr,
  output logic            memRd,
  output logic [3:0]      dstReg,
  output logic            regWr,
  output logic            valid,
  output logic [2:0]      flags,
  output logic            PCSrc,
  output logic [15:0]     pcTarget
);

  localparam logic [BR_W-1:0] BR_NEQ  = BR_W'(0);
  localparam logic [BR_W-1:0] BR_EQ   = BR_W'(1);
  localparam logic [BR_W-1:0] BR_GT   = BR_W'(2);
  localparam logic [BR_W-1:0] BR_LT   = BR_W'(3);
  localparam logic [BR_W-1:0] BR_GTE  = BR_W'(4);
  localparam logic [BR_W-1:0] BR_LTE  = BR_W'(5);
  localparam logic [BR_W-1:0] BR_OVFL = BR_W'(6);

  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] wr_data_q,  wr_data_d;
  logic [15:0] pc_tgt_q,   pc_tgt_d;
  logic [3:0]  dst_reg_q,  dst_reg_d;
  logic        valid_q,    valid_d;
  logic        mem_wr_q,   mem_wr_d;
  logic        mem_rd_q,   mem_rd_d;
  logic        reg_wr_q,   reg_wr_d;
  logic [2:0]  flags_q,    flags_d;
  logic        taken_q,    taken_d;
  logic        fired_q,    fired_d;

  logic load;
  logic accept;
  logic cmp;
  logic taken;
  logic flag_n, flag_z, flag_v;

  assign load   = ~stall;
  assign accept = ex_valid & ~flush;
  assign flag_n = flags_q[2];
  assign flag_z = flags_q[1];
  assign flag_v = flags_q[0];

  // Branch condition against the flags already in the register (pre-update).
  always_comb begin
    cmp = 1'b1;
    case (ex_branchOp)
      BR_NEQ:  cmp = ~flag_z;
      BR_EQ:   cmp = flag_z;
      BR_GT:   cmp = ~flag_z & ~flag_n;
      BR_LT:   cmp = flag_n;
      BR_GTE:  cmp = ~flag_n;
      BR_LTE:  cmp = flag_n | flag_z;
      BR_OVFL: cmp = flag_v;
      default: cmp = 1'b1;
    endcase
  end

  assign taken = accept & ((ex_sawBr & cmp) | ex_sawJ);

  // Next-state for the bundle, flags and redirect bookkeeping.
  always_comb begin
    mem_addr_d = mem_addr_q;
    wr_data_d  = wr_data_q;
    pc_tgt_d   = pc_tgt_q;
    dst_reg_d  = dst_reg_q;
    valid_d    = valid_q;
    mem_wr_d   = mem_wr_q;
    mem_rd_d   = mem_rd_q;
    reg_wr_d   = reg_wr_q;
    flags_d    = flags_q;
    taken_d    = taken_q;
    fired_d    = fired_q;
    if (load) begin
      valid_d  = accept;
      mem_wr_d = accept & ex_memWr;
      mem_rd_d = accept & ex_memRd;
      reg_wr_d = accept & ex_regWr;
      taken_d  = taken;
      fired_d  = 1'b0;
      // Bubbles leave the data fields untouched; they are don't-care anyway.
      if (accept) begin
        mem_addr_d = ex_aluOut;
        wr_data_d  = ex_wrData;
        pc_tgt_d   = ex_pcTarget;
        dst_reg_d  = ex_dstReg;
        if (ex_setFlags) flags_d = ex_flags;
      end
    end else if (PCSrc) begin
      // Held in MEM: remember the pulse went out so it is not repeated.
      fired_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q <= 16'h0000;
      wr_data_q  <= 16'h0000;
      pc_tgt_q   <= 16'h0000;
      dst_reg_q  <= 4'h0;
      valid_q    <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      reg_wr_q   <= 1'b0;
      flags_q    <= 3'b000;
      taken_q    <= 1'b0;
      fired_q    <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      wr_data_q  <= wr_data_d;
      pc_tgt_q   <= pc_tgt_d;
      dst_reg_q  <= dst_reg_d;
      valid_q    <= valid_d;
      mem_wr_q   <= mem_wr_d;
      mem_rd_q   <= mem_rd_d;
      reg_wr_q   <= reg_wr_d;
      flags_q    <= flags_d;
      taken_q    <= taken_d;
      fired_q    <= fired_d;
    end
  end

  assign memAddr  = mem_addr_q;
  assign wrData   = wr_data_q;
  assign pcTarget = pc_tgt_q;
  assign dstReg   = dst_reg_q;
  assign valid    = valid_q;
  assign memWr    = mem_wr_q;
  assign memRd    = mem_rd_q;
  assign regWr    = reg_wr_q;
  assign flags    = flags_q;
  assign PCSrc    = taken_q & ~fired_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Testbench for ex_mem_pipe: directed scenarios plus randomized traffic
// against a cycle-level reference model of the pipeline register.
module tb_ex_mem_pipe;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, ex_valid;
  logic [15:0] ex_aluOut, ex_wrData, ex_pcTarget;
  logic [3:0]  ex_dstReg;
  logic        ex_regWr, ex_memWr, ex_memRd, ex_sawBr, ex_sawJ, ex_setFlags;
  logic [2:0]  ex_branchOp, ex_flags;
  logic [15:0] memAddr, wrData, pcTarget;
  logic        memWr, memRd, regWr, valid, PCSrc;
  logic [3:0]  dstReg;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;

  ex_mem_pipe #(.BR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_aluOut(ex_aluOut), .ex_wrData(ex_wrData), .ex_pcTarget(ex_pcTarget),
    .ex_dstReg(ex_dstReg), .ex_regWr(ex_regWr), .ex_memWr(ex_memWr),
    .ex_memRd(ex_memRd), .ex_sawBr(ex_sawBr), .ex_sawJ(ex_sawJ),
    .ex_branchOp(ex_branchOp), .ex_setFlags(ex_setFlags), .ex_flags(ex_flags),
    .memAddr(memAddr), .wrData(wrData), .memWr(memWr), .memRd(memRd),
    .dstReg(dstReg), .regWr(regWr), .valid(valid), .flags(flags),
    .PCSrc(PCSrc), .pcTarget(pcTarget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what MEM holds, plus whether the last edge was a load.
  logic        m_valid, m_memWr, m_memRd, m_regWr, m_taken, m_lastload;
  logic [15:0] m_addr, m_wd, m_tgt;
  logic [3:0]  m_dst;
  logic [2:0]  m_flags;

  function automatic bit cond(input logic [2:0] op, input logic [2:0] f);
    bit n, z, v;
    n = f[2]; z = f[1]; v = f[0];
    case (op)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [59:0] exp_vec();
    return {m_valid, m_memWr, m_memRd, m_regWr, m_dst, m_addr, m_wd, m_tgt,
            m_flags, (m_taken && m_lastload)};
  endfunction

  function automatic logic [59:0] dut_vec();
    return {valid, memWr, memRd, regWr, dstReg, memAddr, wrData, pcTarget,
            flags, PCSrc};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_memWr = 0; m_memRd = 0; m_regWr = 0; m_taken = 0;
    m_lastload = 0; m_addr = 0; m_wd = 0; m_tgt = 0; m_dst = 0; m_flags = 0;
  endtask

  task automatic idle();
    stall = 0; flush = 0; ex_valid = 0; ex_aluOut = 0; ex_wrData = 0;
    ex_pcTarget = 0; ex_dstReg = 0; ex_regWr = 0; ex_memWr = 0; ex_memRd = 0;
    ex_sawBr = 0; ex_sawJ = 0; ex_branchOp = 0; ex_setFlags = 0; ex_flags = 0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    bit t;
    if (!stall) begin
      t = ex_valid && !flush;
      m_valid = t;
      m_memWr = t && ex_memWr;
      m_memRd = t && ex_memRd;
      m_regWr = t && ex_regWr;
      m_taken = t && ((ex_sawBr && cond(ex_branchOp, m_flags)) || ex_sawJ);
      if (t) begin
        m_addr = ex_aluOut; m_wd = ex_wrData; m_tgt = ex_pcTarget; m_dst = ex_dstReg;
        if (ex_setFlags) m_flags = ex_flags;
      end
      m_lastload = 1;
    end else begin
      m_lastload = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [2:0] f);
    idle(); ex_valid = 1; ex_setFlags = 1; ex_flags = f; ex_regWr = 1;
    tick();
  endtask

  task automatic test_reset();
    set_flags(3'b111);
    idle(); ex_valid = 1; ex_memWr = 1; ex_aluOut = 16'h1234; ex_wrData = 16'hBEEF;
    ex_pcTarget = 16'h5555; ex_dstReg = 4'h7; ex_sawJ = 1;
    tick();
    checks++;
    if (memWr !== 1'b1 || flags !== 3'b111) begin
      errors++; $display("FAIL reset_pre memWr=%b flags=%b required 1/111", memWr, flags);
    end
    #2 rst_n = 0; model_reset();
    #1;
    checks++;
    if (dut_vec() !== 60'h0) begin
      errors++; $display("FAIL reset_async outputs=%h required 0", dut_vec());
    end
    rst_n = 1;
    idle(); ex_valid = 1; ex_memRd = 1; ex_aluOut = 16'h0040; ex_dstReg = 4'h3; ex_regWr = 1;
    tick();
    checks++;
    if (memRd !== 1'b1 || memAddr !== 16'h0040 || valid !== 1'b1) begin
      errors++; $display("FAIL reset_first_load memRd=%b memAddr=%h valid=%b required 1/0040/1",
                         memRd, memAddr, valid);
    end
  endtask

  task automatic test_flags_beq();
    for (int k = 0; k < 2; k++) begin
      set_flags(3'b010);
      checks++;
      if (flags !== 3'b010) begin
        errors++; $display("FAIL beq_flags got %b required 010", flags);
      end
      idle(); ex_valid = 1; ex_sawBr = 1; ex_pcTarget = 16'h0123;
      ex_branchOp = (k == 0) ? 3'b001 : 3'b000;
      tick();
      checks++;
      if (PCSrc !== (k == 0) || pcTarget !== 16'h0123) begin
        errors++; $display("FAIL beq_pulse op=%0d PCSrc=%b pcTarget=%h required %0d/0123",
                           k, PCSrc, pcTarget, (k == 0));
      end
      idle(); tick();
      checks++;
      if (PCSrc !== 1'b0) begin
        errors++; $display("FAIL beq_fall op=%0d PCSrc=%b required 0", k, PCSrc);
      end
    end
  endtask

  task automatic test_sweep();
    logic [2:0] fl [4];
    logic [2:0] op;
    bit exp;
    fl[0] = 3'b000; fl[1] = 3'b001; fl[2] = 3'b010; fl[3] = 3'b100;
    for (int o = 0; o < 9; o++) begin
      for (int i = 0; i < 4; i++) begin
        set_flags(fl[i]);
        op = 3'(o);
        idle(); ex_valid = 1; ex_pcTarget = 16'h0A00 + 16'(o);
        if (o == 8) begin ex_sawJ = 1; ex_branchOp = 3'b001; exp = 1; end
        else begin ex_sawBr = 1; ex_branchOp = op; exp = cond(op, fl[i]); end
        tick();
        checks++;
        if (PCSrc !== exp) begin
          errors++; $display("FAIL sweep op=%0d flags=%b PCSrc=%b required %0d",
                             o, fl[i], PCSrc, exp);
        end
      end
    end
    idle(); tick();
  endtask

  task automatic test_stall();
    set_flags(3'b010);
    idle(); ex_valid = 1; ex_sawBr = 1; ex_branchOp = 3'b001; ex_pcTarget = 16'h0777;
    ex_aluOut = 16'h0011; ex_dstReg = 4'h9; ex_regWr = 1;
    tick();
    checks++;
    if (PCSrc !== 1'b1) begin
      errors++; $display("FAIL stall_first PCSrc=%b required 1", PCSrc);
    end
    idle(); stall = 1; ex_valid = 1; ex_setFlags = 1; ex_flags = 3'b101; ex_aluOut = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (PCSrc !== 1'b0 || flags !== 3'b010 || pcTarget !== 16'h0777 ||
          memAddr !== 16'h0011 || dstReg !== 4'h9 || valid !== 1'b1 || regWr !== 1'b1) begin
        errors++; $display("FAIL stall_hold c=%0d PCSrc=%b flags=%b pcTarget=%h memAddr=%h required 0/010/0777/0011",
                           c, PCSrc, flags, pcTarget, memAddr);
      end
    end
    idle(); tick();
  endtask

  task automatic test_flush();
    set_flags(3'b100);
    idle(); ex_valid = 1; ex_memWr = 1; ex_setFlags = 1; ex_flags = 3'b011; flush = 1;
    tick();
    checks++;
    if (valid !== 1'b0 || memWr !== 1'b0 || flags !== 3'b100) begin
      errors++; $display("FAIL flush valid=%b memWr=%b flags=%b required 0/0/100", valid, memWr, flags);
    end
    idle(); ex_valid = 1; ex_memWr = 1; ex_aluOut = 16'h0C0C;
    tick();
    idle(); ex_valid = 1; ex_aluOut = 16'h0D0D; flush = 1; stall = 1;
    tick();
    checks++;
    if (valid !== 1'b1 || memWr !== 1'b1 || memAddr !== 16'h0C0C) begin
      errors++; $display("FAIL flush_stall valid=%b memWr=%b memAddr=%h required 1/1/0C0C",
                         valid, memWr, memAddr);
    end
    idle(); tick();
  endtask

  task automatic test_gating();
    idle(); ex_valid = 0; ex_memWr = 1; ex_regWr = 1; ex_memRd = 1; ex_sawJ = 1;
    tick();
    checks++;
    if (memWr !== 1'b0 || regWr !== 1'b0 || memRd !== 1'b0 || PCSrc !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL gating memWr=%b regWr=%b memRd=%b PCSrc=%b required 0",
                         memWr, regWr, memRd, PCSrc);
    end
  endtask

  task automatic test_back_to_back();
    idle(); ex_valid = 1; ex_sawJ = 1; ex_pcTarget = 16'h0100;
    tick();
    checks++;
    if (PCSrc !== 1'b1 || pcTarget !== 16'h0100) begin
      errors++; $display("FAIL b2b_first PCSrc=%b pcTarget=%h required 1/0100", PCSrc, pcTarget);
    end
    ex_pcTarget = 16'h0200;
    tick();
    checks++;
    if (PCSrc !== 1'b1 || pcTarget !== 16'h0200) begin
      errors++; $display("FAIL b2b_second PCSrc=%b pcTarget=%h required 1/0200", PCSrc, pcTarget);
    end
    idle(); tick();
    checks++;
    if (PCSrc !== 1'b0) begin
      errors++; $display("FAIL b2b_end PCSrc=%b required 0", PCSrc);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      stall       = ($urandom_range(3) == 0);
      flush       = ($urandom_range(6) == 0);
      ex_valid    = ($urandom_range(4) != 0);
      ex_aluOut   = 16'($urandom);
      ex_wrData   = 16'($urandom);
      ex_pcTarget = 16'($urandom);
      ex_dstReg   = 4'($urandom);
      ex_regWr    = 1'($urandom);
      ex_memWr    = 1'($urandom);
      ex_memRd    = 1'($urandom);
      ex_sawBr    = ($urandom_range(2) == 0);
      ex_sawJ     = ($urandom_range(7) == 0);
      ex_branchOp = 3'($urandom);
      ex_setFlags = ($urandom_range(2) == 0);
      ex_flags    = 3'($urandom);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random c=%0d outputs=%h required %h", c, dut_vec(), exp_vec());
      end
    end
    idle(); tick();
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    #12 rst_n = 1;
    checks++;
    if (dut_vec() !== 60'h0) begin
      errors++; $display("FAIL reset_init outputs=%h required 0", dut_vec());
    end
    test_reset();
    test_flags_beq();
    test_sweep();
    test_stall();
    test_flush();
    test_gating();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
